fir_reload_seq: RTL and testbench
=================================

Name: fir_reload_seq

Overview:
Sequences coefficient reloads into the dac channel's fir_filter configuration port (cfg_din/cfg_ce).
- Software writes coefficients into a double-banked shadow buffer through a simple write port driven by the channel register block.
- A commit pulse swaps banks and streams all LEN words into the filter, while software keeps writing the other bank.
- Reports busy, done, and a sticky overrun error.

Parameters:
- LEN, 21, number of filter taps (words per reload).
- COEF_W, 25, width of one configuration word (matches filter_cfg_din).
- CE_GAP, 0, idle cycles inserted between consecutive cfg_ce pulses (0..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- wr_en  in  1  shadow write strobe.
- wr_addr  in  $clog2(LEN)  coefficient index, 0..LEN-1.
- wr_data  in  COEF_W  coefficient word.
- commit  in  1  single-cycle request to load the written bank.
- cfg_din  out  COEF_W  word to the filter configuration port.
- cfg_ce  out  1  word-valid strobe to the filter.
- busy  out  1  high from accepted commit until done.
- done  out  1  one-cycle pulse after the last word is sent.
- pending  out  1  a commit is queued behind the current load.
- err_overrun  out  1  sticky error flag; cleared by clear_err.
- clear_err  in  1  clears err_overrun.
- checksum  out  32  see Optional Feature.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; wr_bank=0; rd_bank=1.
  - All outputs 0: cfg_din, cfg_ce, busy, done, pending, err_overrun, checksum.
  - RAM contents are not cleared.
  - Reset mid-load aborts the load immediately; the next cycle has cfg_ce=0.
- Writes:
  - wr_en writes wr_data to bank wr_bank at wr_addr in every state.
  - wr_addr >= LEN: write is ignored.
  - A write in the same cycle as an accepted commit lands in the bank being committed.
- States: IDLE, PRIME, EMIT, GAP, DONE.
- IDLE:
  - commit: rd_bank<=wr_bank, wr_bank flips, idx<=LEN-1, busy<=1, go to PRIME.
- PRIME:
  - Issues the RAM read of idx (1-cycle read latency), then goes to EMIT.
  - First cfg_ce is therefore asserted 2 cycles after commit.
- EMIT:
  - cfg_ce=1 for exactly one cycle; cfg_din=bank[rd_bank][idx].
  - idx==0: go to DONE.
  - Otherwise idx decrements, and the next state is GAP if CE_GAP>0, else EMIT (back-to-back, with the read pipelined).
  - Word order is idx LEN-1 down to 0 (last tap first).
- GAP: waits CE_GAP cycles with cfg_ce=0; the final gap cycle issues the read, then goes to EMIT.
- cfg_din holds its last value when cfg_ce=0.
- DONE:
  - done=1 for one cycle.
  - If pending, or commit this cycle: swap banks as in IDLE, clear pending, go to PRIME (busy stays 1).
  - Otherwise busy<=0 and go to IDLE.
- commit while busy (PRIME/EMIT/GAP):
  - pending=0: pending<=1, no swap.
  - pending=1: err_overrun<=1; the request merges with the queued one.
- commit in DONE while pending=1: err_overrun<=1; a single reload is started.
- clear_err has priority lower than a same-cycle overrun set.
- Throughput: one reload = LEN + (LEN-1)*CE_GAP + 2 cycles (PRIME + DONE).

Optional Feature:
- Macro FIR_RELOAD_CHECKSUM_EN.
- Defined:
  - checksum accumulates the 32-bit wrapping sum of the zero-extended cfg_din on each cfg_ce.
  - It is cleared at each accepted commit (load start) and holds its value after done.
- Undefined: checksum is tied to 0 and no accumulator logic exists.

Decomposition:
- Package fir_reload_pkg:
  - state enum typedef (IDLE, PRIME, EMIT, GAP, DONE).
  - default LEN/COEF_W constants.
  - localparam for idx width.
- Sub-module coef_bank_ram:
  - 2*LEN x COEF_W; one write port, one synchronous read port.
  - Address = {bank, idx}; 1-cycle read latency; inferrable as distributed or block RAM.

Test Plan:
- Basic load (LEN=21, CE_GAP=0): write words 0..20 = idx+100, commit.
  - Expect cfg_ce high for 21 consecutive cycles starting 2 cycles after commit.
  - Expect cfg_din 120,119,...,100; done 1 cycle after the last word; busy low the next cycle.
- CE_GAP=2: same load.
  - Expect cfg_ce pulses spaced 3 cycles apart; 21 pulses total.
  - Expect done on cycle 2+21+40=63 after commit.
- Double buffer: during a load, write all words = 0x1FFFFFF and commit once.
  - Expect pending=1; first load data unchanged.
  - Second load starts directly from DONE and emits 0x1FFFFFF x21; busy stays 1 throughout.
- Overrun: three commits during one load.
  - Expect err_overrun=1 and exactly two loads.
  - clear_err then clears the flag.
- Reset mid-load: drive reset=0 at word 10.
  - Expect cfg_ce=0, busy=0, pending=0 the next cycle.
  - A new commit after release loads from bank 0.
- Checksum (macro defined): words all =1.
  - Expect checksum=21 after done; it resets to 0 at the next commit.

Source files
------------

// File: rtl/fir_reload_pkg.sv
// Shared types and default sizing for the fir_reload_seq coefficient reload sequencer.
package fir_reload_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        EMIT  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int LEN_DEF    = 21;
    localparam int COEF_W_DEF = 25;
    localparam int CE_GAP_DEF = 0;
    localparam int IDX_W_DEF  = $clog2(LEN_DEF);
    localparam int GAP_CNT_W  = 4;

endpackage

// File: rtl/coef_bank_ram.sv
// Double-banked coefficient store: one write port, one registered read port, address {bank, idx}.
module coef_bank_ram
    import fir_reload_pkg::*;
#(
    parameter int LEN    = LEN_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W:0]    wr_addr,
    input  logic [COEF_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W:0]    rd_addr,
    output logic [COEF_W-1:0] rd_data
);

    logic [COEF_W-1:0] mem_r [0:1][0:LEN-1];
    logic [COEF_W-1:0] rd_data_r;

    // Storage write; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr[IDX_W]][wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Read data register doubles as the held output word, so it is the one thing reset here
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_r <= {COEF_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr[IDX_W]][rd_addr[IDX_W-1:0]];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/fir_reload_seq.sv
// Streams a committed coefficient bank into the filter config port, last tap first.
// Optional running checksum of emitted words under FIR_RELOAD_CHECKSUM_EN.
module fir_reload_seq
    import fir_reload_pkg::*;
#(
    parameter int LEN    = LEN_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int CE_GAP = CE_GAP_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [$clog2(LEN)-1:0]  wr_addr,
    input  logic [COEF_W-1:0]       wr_data,
    input  logic                    commit,
    output logic [COEF_W-1:0]       cfg_din,
    output logic                    cfg_ce,
    output logic                    busy,
    output logic                    done,
    output logic                    pending,
    output logic                    err_overrun,
    input  logic                    clear_err,
    output logic [31:0]             checksum
);

    localparam int IDX_W = $clog2(LEN);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(LEN - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = (CE_GAP > 0) ? GAP_CNT_W'(CE_GAP - 1) : {GAP_CNT_W{1'b0}};

    state_t                 state_r, state_s;
    logic                   wr_bank_r, wr_bank_s;
    logic                   rd_bank_r, rd_bank_s;
    logic [IDX_W-1:0]       idx_r, idx_s;
    logic [GAP_CNT_W-1:0]   gap_cnt_r, gap_cnt_s;
    logic                   pending_r, pending_s;
    logic                   err_r, err_s;
    logic                   busy_r, done_r, cfg_ce_r;
    logic                   start_s, overrun_s;
    logic                   ram_wr_s, ram_rd_s;
    logic [IDX_W:0]         ram_wr_addr_s, ram_rd_addr_s;

    // Next-state, bank swap, queueing and overrun decisions
    always_comb begin
        state_s   = state_r;
        wr_bank_s = wr_bank_r;
        rd_bank_s = rd_bank_r;
        idx_s     = idx_r;
        gap_cnt_s = gap_cnt_r;
        pending_s = pending_r;
        start_s   = 1'b0;
        overrun_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (commit) begin
                    start_s = 1'b1;
                    state_s = PRIME;
                end else begin
                    state_s = IDLE;
                end
            end
            PRIME: begin
                state_s = EMIT;
            end
            EMIT: begin
                if (idx_r == {IDX_W{1'b0}}) begin
                    state_s = DONE;
                end else begin
                    idx_s = idx_r - {{(IDX_W-1){1'b0}}, 1'b1};
                    if (CE_GAP > 0) begin
                        state_s   = GAP;
                        gap_cnt_s = GAP_LOAD;
                    end else begin
                        state_s = EMIT;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_r == {GAP_CNT_W{1'b0}}) begin
                    state_s = EMIT;
                end else begin
                    gap_cnt_s = gap_cnt_r - {{(GAP_CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                if (pending_r || commit) begin
                    start_s   = 1'b1;
                    overrun_s = pending_r && commit;
                    state_s   = PRIME;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // A commit during an active load is queued once; a second one is an overrun
        if (commit && ((state_r == PRIME) || (state_r == EMIT) || (state_r == GAP))) begin
            if (pending_r) begin
                overrun_s = 1'b1;
            end else begin
                pending_s = 1'b1;
            end
        end else begin
            overrun_s = overrun_s;
        end

        if (start_s) begin
            rd_bank_s = wr_bank_r;
            wr_bank_s = ~wr_bank_r;
            idx_s     = IDX_LAST;
            pending_s = 1'b0;
        end else begin
            rd_bank_s = rd_bank_s;
        end

        if (overrun_s) begin
            err_s = 1'b1;
        end else if (clear_err) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // The read is issued the cycle before each EMIT, for the word EMIT will present
    always_comb begin
        ram_wr_s      = wr_en && (wr_addr <= IDX_LAST);
        ram_wr_addr_s = {wr_bank_r, wr_addr};
        ram_rd_s      = (state_s == EMIT);
        ram_rd_addr_s = {rd_bank_r, idx_s};
    end

    // Sequencer state and registered status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b1;
            idx_r     <= {IDX_W{1'b0}};
            gap_cnt_r <= {GAP_CNT_W{1'b0}};
            pending_r <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            cfg_ce_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            wr_bank_r <= wr_bank_s;
            rd_bank_r <= rd_bank_s;
            idx_r     <= idx_s;
            gap_cnt_r <= gap_cnt_s;
            pending_r <= pending_s;
            err_r     <= err_s;
            busy_r    <= (state_s != IDLE);
            done_r    <= (state_s == DONE);
            cfg_ce_r  <= (state_s == EMIT);
        end
    end

    coef_bank_ram #(
        .LEN    (LEN),
        .COEF_W (COEF_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (ram_wr_s),
        .wr_addr (ram_wr_addr_s),
        .wr_data (wr_data),
        .rd_en   (ram_rd_s),
        .rd_addr (ram_rd_addr_s),
        .rd_data (cfg_din)
    );

`ifdef FIR_RELOAD_CHECKSUM_EN
    logic [31:0] checksum_r;

    // Wrapping sum of emitted words, restarted when a load is accepted
    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum_r <= 32'd0;
        end else if (start_s) begin
            checksum_r <= 32'd0;
        end else if (cfg_ce_r) begin
            checksum_r <= checksum_r + 32'(cfg_din);
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = 32'd0;
`endif

    assign cfg_ce      = cfg_ce_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign pending     = pending_r;
    assign err_overrun = err_r;

endmodule

// File: tb/tb_fir_reload_seq.sv
// Directed bench for fir_reload_seq: one instance with CE_GAP=0, one with CE_GAP=2.
module tb_fir_reload_seq;

    localparam int LEN    = 21;
    localparam int COEF_W = 25;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [COEF_W-1:0] wr_data;
    logic              commit, commit_g, clear_err;

    logic [COEF_W-1:0] cfg_din, cfg_din_g;
    logic              cfg_ce, busy, done, pending, err_overrun;
    logic              cfg_ce_g, busy_g, done_g, pending_g, err_g;
    logic [31:0]       checksum, checksum_g;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fir_reload_seq #(.LEN(LEN), .COEF_W(COEF_W), .CE_GAP(0)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .cfg_din(cfg_din), .cfg_ce(cfg_ce), .busy(busy), .done(done),
        .pending(pending), .err_overrun(err_overrun), .clear_err(clear_err), .checksum(checksum)
    );

    fir_reload_seq #(.LEN(LEN), .COEF_W(COEF_W), .CE_GAP(2)) dut_g (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit_g), .cfg_din(cfg_din_g), .cfg_ce(cfg_ce_g), .busy(busy_g), .done(done_g),
        .pending(pending_g), .err_overrun(err_g), .clear_err(clear_err), .checksum(checksum_g)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = '0;
        commit = 1'b0; commit_g = 1'b0; clear_err = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic write_bank(input bit all_ones, input bit use_idx);
        for (int i = 0; i < LEN; i++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            wr_data = use_idx ? 25'(i + 100) : (all_ones ? 25'h1FFFFFF : 25'd1);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({cfg_din, cfg_ce, busy, done, pending, err_overrun, checksum} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs din=%0h ce=%0b busy=%0b done=%0b pend=%0b err=%0b sum=%0h exp all 0",
                     cfg_din, cfg_ce, busy, done, pending, err_overrun, checksum);
        end
        n_tests++;
        if ({cfg_din_g, cfg_ce_g, busy_g, done_g, pending_g, err_g, checksum_g} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_gap din=%0h ce=%0b busy=%0b exp all 0", cfg_din_g, cfg_ce_g, busy_g);
        end
    endtask

    task automatic test_basic_load();
        logic [COEF_W-1:0] exp_din;
        logic [31:0]       exp_sum;
        do_reset();
        write_bank(1'b0, 1'b1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || cfg_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_prime busy=%0b ce=%0b exp busy=1 ce=0", busy, cfg_ce);
        end
        for (int k = 0; k < LEN; k++) begin
            tick();
            exp_din = 25'(120 - k);
            n_tests++;
            if (cfg_ce !== 1'b1 || cfg_din !== exp_din || done !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_word k=%0d ce=%0b din=%0d done=%0b exp ce=1 din=%0d done=0",
                         k, cfg_ce, cfg_din, done, exp_din);
            end
        end
        tick();
`ifdef FIR_RELOAD_CHECKSUM_EN
        exp_sum = 32'd2310;
`else
        exp_sum = 32'd0;
`endif
        n_tests++;
        if (done !== 1'b1 || cfg_ce !== 1'b0 || cfg_din !== 25'd100 || busy !== 1'b1 || checksum !== exp_sum) begin
            n_fail++;
            $display("FAIL basic_done done=%0b ce=%0b din=%0d busy=%0b sum=%0d exp 1 0 100 1 %0d",
                     done, cfg_ce, cfg_din, busy, checksum, exp_sum);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle busy=%0b done=%0b exp 0 0", busy, done);
        end
    endtask

    task automatic test_gap();
        int pulses = 0;
        logic exp_ce;
        logic [COEF_W-1:0] exp_din;
        commit_g = 1'b1;
        tick();
        commit_g = 1'b0;
        for (int t = 1; t <= 66; t++) begin
            if (t > 1) tick();
            exp_ce = (t >= 2) && (t <= 62) && (((t - 2) % 3) == 0);
            n_tests++;
            if (cfg_ce_g !== exp_ce || done_g !== (t == 63)) begin
                n_fail++;
                $display("FAIL gap_timing t=%0d ce=%0b done=%0b exp ce=%0b done=%0b",
                         t, cfg_ce_g, done_g, exp_ce, (t == 63));
            end
            if (exp_ce) begin
                exp_din = 25'(120 - (t - 2) / 3);
                n_tests++;
                if (cfg_din_g !== exp_din) begin
                    n_fail++;
                    $display("FAIL gap_data t=%0d din=%0d exp %0d", t, cfg_din_g, exp_din);
                end
            end
            if (cfg_ce_g === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 21 || busy_g !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_count pulses=%0d busy=%0b exp 21 0", pulses, busy_g);
        end
    endtask

    task automatic test_back_to_back();
        logic [COEF_W-1:0] exp_din;
        do_reset();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_tests++;
        if (pending !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pend0 pending=%0b exp 0", pending);
        end
        for (int k = 0; k < LEN; k++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(k);
            wr_data = 25'h1FFFFFF;
            commit  = (k == 10);
            tick();
            exp_din = 25'(120 - k);
            n_tests++;
            if (cfg_ce !== 1'b1 || cfg_din !== exp_din) begin
                n_fail++;
                $display("FAIL b2b_first k=%0d ce=%0b din=%0h exp ce=1 din=%0h", k, cfg_ce, cfg_din, exp_din);
            end
        end
        wr_en  = 1'b0;
        commit = 1'b0;
        n_tests++;
        if (pending !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pend1 pending=%0b exp 1", pending);
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done1 done=%0b busy=%0b exp 1 1", done, busy);
        end
        tick();
        n_tests++;
        if (pending !== 1'b0 || busy !== 1'b1 || cfg_ce !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_prime2 pend=%0b busy=%0b ce=%0b done=%0b exp 0 1 0 0", pending, busy, cfg_ce, done);
        end
        for (int k = 0; k < LEN; k++) begin
            tick();
            n_tests++;
            if (cfg_ce !== 1'b1 || cfg_din !== 25'h1FFFFFF || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_second k=%0d ce=%0b din=%0h busy=%0b exp 1 1ffffff 1", k, cfg_ce, cfg_din, busy);
            end
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || err_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done2 done=%0b err=%0b exp 1 0", done, err_overrun);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle busy=%0b exp 0", busy);
        end
    endtask

    task automatic test_overrun();
        int dones = 0;
        do_reset();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int t = 2; t <= 70; t++) begin
            commit = (t == 5) || (t == 8) || (t == 11);
            tick();
            commit = 1'b0;
            if (t == 6) begin
                n_tests++;
                if (pending !== 1'b1 || err_overrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovr_first pend=%0b err=%0b exp 1 0", pending, err_overrun);
                end
            end
            if (done === 1'b1) dones++;
        end
        n_tests++;
        if (dones != 2 || err_overrun !== 1'b1 || busy !== 1'b0 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_loads dones=%0d err=%0b busy=%0b pend=%0b exp 2 1 0 0", dones, err_overrun, busy, pending);
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        n_tests++;
        if (err_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear err=%0b exp 0", err_overrun);
        end
    endtask

    task automatic test_reset_mid_load();
        bit idle_seen = 1'b0;
        do_reset();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            commit = (k == 5);
            tick();
            commit = 1'b0;
        end
        n_tests++;
        if (cfg_din !== 25'd110 || pending !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_word10 din=%0d pend=%0b exp 110 1", cfg_din, pending);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (cfg_ce !== 1'b0 || busy !== 1'b0 || pending !== 1'b0 || cfg_din !== 25'd0) begin
            n_fail++;
            $display("FAIL mid_abort ce=%0b busy=%0b pend=%0b din=%0d exp 0 0 0 0", cfg_ce, busy, pending, cfg_din);
        end
        reset  = 1'b1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        n_tests++;
        if (cfg_ce !== 1'b1 || cfg_din !== 25'd120) begin
            n_fail++;
            $display("FAIL mid_bank0 ce=%0b din=%0d exp 1 120", cfg_ce, cfg_din);
        end
        for (int i = 0; i < 40 && !idle_seen; i++) begin
            tick();
            if (busy === 1'b0) idle_seen = 1'b1;
        end
        n_tests++;
        if (!idle_seen) begin
            n_fail++;
            $display("FAIL mid_drain busy=%0b exp 0 within 40 cycles", busy);
        end
    endtask

    task automatic test_checksum();
        logic [31:0] exp_sum;
        bit done_seen = 1'b0;
`ifdef FIR_RELOAD_CHECKSUM_EN
        exp_sum = 32'd21;
`else
        exp_sum = 32'd0;
`endif
        do_reset();
        write_bank(1'b0, 1'b0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            tick();
            if (done === 1'b1) done_seen = 1'b1;
        end
        n_tests++;
        if (!done_seen || checksum !== exp_sum) begin
            n_fail++;
            $display("FAIL csum_done seen=%0b sum=%0d exp seen=1 sum=%0d", done_seen, checksum, exp_sum);
        end
        tick();
        n_tests++;
        if (checksum !== exp_sum) begin
            n_fail++;
            $display("FAIL csum_hold sum=%0d exp %0d", checksum, exp_sum);
        end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_tests++;
        if (checksum !== 32'd0) begin
            n_fail++;
            $display("FAIL csum_clear sum=%0d exp 0", checksum);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_load();
        test_gap();
        test_back_to_back();
        test_overrun();
        test_reset_mid_load();
        test_checksum();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
